// File: rtl/frame_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : frame_write_scheduler_if
// Brief   : Stream input and shared band write bus of the frame write scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface frame_write_scheduler_if #(
  parameter int NB_BANDS     = 2,
  parameter int W_DATA_WIDTH = 128,
  parameter int ADDR_W       = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic [W_DATA_WIDTH-1:0] in_data;
  logic                    in_sof;
  logic [ADDR_W-1:0]       w_addr_input;
  logic [W_DATA_WIDTH-1:0] w_data;
  logic [NB_BANDS-1:0]     write;
  logic                    new_frame;

  // master: the scheduler, which drives the band write bus and accepts the stream
  modport master (
    input  in_valid, in_data, in_sof,
    output in_ready, w_addr_input, w_data, write, new_frame
  );

  modport slave (
    output in_valid, in_data, in_sof,
    input  in_ready, w_addr_input, w_data, write, new_frame
  );
endinterface
`default_nettype wire

// File: rtl/frame_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : frame_write_scheduler
// Brief   : Loads a band-major frame into all band back buffers, then swaps
//           every band together on the next turn_tick rising edge.
// Revision: 1.0 - initial release
// ============================================================================
module frame_write_scheduler #(
  parameter int NB_BANDS      = 2,
  parameter int BIT_PER_COLOR = 8,
  parameter int NB_LED_COLUMN = 32,
  parameter int NB_ANGLES     = 128,
  parameter int W_DATA_WIDTH  = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  frame_write_scheduler_if.master bus,
  input  logic                    turn_tick,
  input  logic                    err_clr,
  output logic                    frame_pending,
  output logic                    frame_error,
  output logic [15:0]             frame_count
);
  localparam int HALF_WORDS = 3 * BIT_PER_COLOR * NB_LED_COLUMN * NB_ANGLES / W_DATA_WIDTH;
  localparam int ADDR_W     = $clog2(HALF_WORDS);
  localparam int BAND_W     = (NB_BANDS > 1) ? $clog2(NB_BANDS) : 1;

  localparam logic [ADDR_W-1:0]   c_LAST_ADDR = ADDR_W'(HALF_WORDS - 1);
  localparam logic [BAND_W-1:0]   c_LAST_BAND = BAND_W'(NB_BANDS - 1);
  localparam logic [NB_BANDS-1:0] c_BAND0     = NB_BANDS'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_TICK = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [BAND_W-1:0]   r_band;
  logic                r_tick_d;
  logic                w_accept;
  logic                w_tick_edge;
  logic                w_last;
  logic [NB_BANDS-1:0] w_band_onehot;

  always_comb begin
    w_accept    = bus.in_valid & bus.in_ready;
    w_tick_edge = turn_tick & ~r_tick_d;
    w_last      = (r_band == c_LAST_BAND) && (r_addr == c_LAST_ADDR);
    w_band_onehot = '0;
    for (int b = 0; b < NB_BANDS; b++) begin
      w_band_onehot[b] = (r_band == BAND_W'(b));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_addr           <= '0;
      r_band           <= '0;
      r_tick_d         <= turn_tick;
      bus.in_ready     <= 1'b0;
      bus.write        <= '0;
      bus.w_addr_input <= '0;
      bus.w_data       <= '0;
      bus.new_frame    <= 1'b0;
      frame_pending    <= 1'b0;
      frame_error      <= 1'b0;
      frame_count      <= '0;
    end else begin
      r_tick_d      <= turn_tick;
      bus.write     <= '0;
      bus.new_frame <= 1'b0;
      if (err_clr) begin
        frame_error <= 1'b0;
      end

      // A start-of-frame word always lands at band 0 / addr 0, in IDLE or mid-load.
      if (w_accept && (bus.in_sof || (r_state == LOAD))) begin
        bus.w_data <= bus.in_data;
        if (bus.in_sof) begin
          bus.write        <= c_BAND0;
          bus.w_addr_input <= '0;
        end else begin
          bus.write        <= w_band_onehot;
          bus.w_addr_input <= r_addr;
        end
      end

      case (r_state)
        IDLE: begin
          // Also re-opens the stream one cycle after the swap pulse.
          bus.in_ready <= 1'b1;
          if (w_accept && bus.in_sof) begin
            r_state <= LOAD;
            r_addr  <= ADDR_W'(1);
            r_band  <= '0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            if (bus.in_sof) begin
              frame_error <= 1'b1;
              r_addr      <= ADDR_W'(1);
              r_band      <= '0;
            end else if (w_last) begin
              r_state       <= WAIT_TICK;
              bus.in_ready  <= 1'b0;
              frame_pending <= 1'b1;
              r_addr        <= '0;
              r_band        <= '0;
            end else if (r_addr == c_LAST_ADDR) begin
              r_addr <= '0;
              r_band <= r_band + BAND_W'(1);
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        WAIT_TICK: begin
          // Edges coinciding with the last handshake were seen in LOAD and are dropped.
          if (w_tick_edge) begin
            bus.new_frame <= 1'b1;
            frame_count   <= frame_count + 16'd1;
            frame_pending <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_frame_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_write_scheduler
// Brief   : Self-checking bench: vector table plus directed frame sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_frame_write_scheduler;
  localparam int NB = 2;
  localparam int DW = 128;
  localparam int AW = 10;
  localparam int HW = 768;
  localparam int FW = NB * HW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        turn_tick = 1'b0;
  logic        err_clr = 1'b0;
  logic        frame_pending;
  logic        frame_error;
  logic [15:0] frame_count;

  frame_write_scheduler_if #(.NB_BANDS(NB), .W_DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  frame_write_scheduler #(
    .NB_BANDS(NB), .BIT_PER_COLOR(8), .NB_LED_COLUMN(32), .NB_ANGLES(128), .W_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .turn_tick(turn_tick), .err_clr(err_clr),
    .frame_pending(frame_pending), .frame_error(frame_error), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit stalled = 1'b0;

  // Band memory model fed from the write bus just after each edge.
  logic [DW-1:0] mem [NB][HW];
  int strobe_cnt = 0;
  int onehot_bad = 0;
  int nf_cnt = 0;
  logic [DW-1:0] frm [FW];

  always @(posedge clk) begin
    #1;
    if (bus.write != '0) begin
      strobe_cnt <= strobe_cnt + 1;
      if ($countones(bus.write) != 1) onehot_bad <= onehot_bad + 1;
      for (int b = 0; b < NB; b++) begin
        if (bus.write[b] && (bus.w_addr_input < AW'(HW))) mem[b][bus.w_addr_input] <= bus.w_data;
      end
    end
    if (bus.new_frame === 1'b1) nf_cnt <= nf_cnt + 1;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_write"}, bus.write, 0);
    check({tag, "_addr"}, bus.w_addr_input, 0);
    check({tag, "_data"}, bus.w_data, 0);
    check({tag, "_new_frame"}, bus.new_frame, 0);
    check({tag, "_pending"}, frame_pending, 0);
    check({tag, "_error"}, frame_error, 0);
    check({tag, "_count"}, frame_count, 0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge just after the handshake edge.
  task automatic send(input logic [DW-1:0] d, input logic sof);
    int guard = 0;
    if (stalled) return;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sof = sof;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++; n_errors++; stalled = 1'b1;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
    end else begin
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
  endtask

  task automatic fill_frame();
    for (int k = 0; k < FW; k++) frm[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic mem_check(input string tag);
    int bad;
    for (int b = 0; b < NB; b++) begin
      bad = 0;
      for (int a = 0; a < HW; a++) if (mem[b][a] !== frm[b * HW + a]) bad++;
      check($sformatf("%s_band%0d_mismatches", tag, b), bad, 0);
    end
  endtask

  typedef struct {
    logic          valid;
    logic          sof;
    logic          tick;
    logic          clr;
    logic [DW-1:0] data;
    logic [NB-1:0] exp_write;
    logic [AW-1:0] exp_addr;
    logic          exp_error;
  } vec_t;

  vec_t vt [14];

  initial begin
    int s0, nf0, rdy_bad;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, nf0, rdy_bad;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;

    // Reset with tick held high: reset values, then no swap from the held level.
    rst = 1'b1; turn_tick = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.in_ready, 1);
    repeat (3) @(negedge clk);
    check("held_tick_no_swap", nf_cnt, 0);
    turn_tick = 1'b0;
    @(negedge clk);

    // Vector table: garbage in IDLE, frame start, restart, err_clr priority.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 128'hA0, 2'b00, 10'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 128'hA1, 2'b00, 10'd0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 128'hA2, 2'b00, 10'd0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 128'hA3, 2'b00, 10'd0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 128'hA4, 2'b00, 10'd0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 128'h00, 2'b00, 10'd0, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 128'hB0, 2'b01, 10'd0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 128'hB1, 2'b01, 10'd1, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 128'h00, 2'b00, 10'd0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 128'hB2, 2'b01, 10'd2, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 128'hC0, 2'b01, 10'd0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 128'hC1, 2'b01, 10'd1, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 128'hD0, 2'b01, 10'd0, 1'b1};
    vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 128'h00, 2'b00, 10'd0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = vt[i].valid; bus.in_sof = vt[i].sof; bus.in_data = vt[i].data;
      turn_tick = vt[i].tick; err_clr = vt[i].clr;
      @(negedge clk);
      check($sformatf("vec%0d_write", i), bus.write, vt[i].exp_write);
      if (vt[i].exp_write != '0) begin
        check($sformatf("vec%0d_addr", i), bus.w_addr_input, vt[i].exp_addr);
        check($sformatf("vec%0d_data", i), bus.w_data, vt[i].data);
      end
      check($sformatf("vec%0d_error", i), frame_error, vt[i].exp_error);
      check($sformatf("vec%0d_new_frame", i), bus.new_frame, 0);
      check($sformatf("vec%0d_ready", i), bus.in_ready, 1);
    end
    err_clr = 1'b0; turn_tick = 1'b0;
    do_reset();

    // Nominal frame, then backpressure with the tick held high.
    fill_frame();
    s0 = strobe_cnt;
    for (int k = 0; k < FW; k++) send(frm[k], k == 0);
    check("nom_ready_drop", bus.in_ready, 0);
    check("nom_pending", frame_pending, 1);
    @(negedge clk);
    check("nom_strobes", strobe_cnt - s0, FW);
    check("nom_onehot_bad", onehot_bad, 0);
    mem_check("nom");
    bus.in_valid = 1'b1; bus.in_data = 128'hDEAD; s0 = strobe_cnt; nf0 = nf_cnt; rdy_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.in_ready) rdy_bad++;
    end
    check("bp_ready_cycles", rdy_bad, 0);
    check("bp_writes", strobe_cnt - s0, 0);
    check("bp_no_swap", nf_cnt - nf0, 0);
    turn_tick = 1'b1;
    @(negedge clk);
    check("nom_new_frame", bus.new_frame, 1);
    check("nom_pending_clear", frame_pending, 0);
    check("nom_count", frame_count, 1);
    check("nom_ready_during_swap", bus.in_ready, 0);
    @(negedge clk);
    check("nom_new_frame_pulse", bus.new_frame, 0);
    check("nom_ready_after_swap", bus.in_ready, 1);
    repeat (10) @(negedge clk);
    check("nom_single_swap", nf_cnt - nf0, 1);
    check("bp_garbage_writes", strobe_cnt - s0, 0);
    bus.in_valid = 1'b0; turn_tick = 1'b0;
    @(negedge clk);

    // Restart at word 300, then a full frame with three ticks during loading.
    fill_frame();
    for (int k = 0; k < 300; k++) send(frm[k], k == 0);
    check("partial_pending", frame_pending, 0);
    check("partial_error", frame_error, 0);
    fill_frame();
    nf0 = nf_cnt;
    send(frm[0], 1'b1);
    check("restart_error", frame_error, 1);
    check("restart_write", bus.write, 2'b01);
    check("restart_addr", bus.w_addr_input, 0);
    check("restart_data", bus.w_data, frm[0]);
    for (int k = 1; k < FW; k++) begin
      if (k == 400 || k == 800 || k == 1200) turn_tick = 1'b1;
      if (k == 450 || k == 850 || k == 1250) turn_tick = 1'b0;
      send(frm[k], 1'b0);
    end
    check("load_ticks_no_swap", nf_cnt - nf0, 0);
    check("load_ticks_count", frame_count, 1);
    check("restart_pending", frame_pending, 1);
    mem_check("restart");
    turn_tick = 1'b1;
    @(negedge clk);
    check("restart_new_frame", bus.new_frame, 1);
    check("restart_count", frame_count, 2);
    turn_tick = 1'b0; err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", frame_error, 0);

    // Tick edge in the same cycle as the last-word handshake.
    fill_frame();
    nf0 = nf_cnt;
    for (int k = 0; k < FW - 1; k++) send(frm[k], k == 0);
    turn_tick = 1'b1;
    send(frm[FW-1], 1'b0);
    repeat (5) @(negedge clk);
    check("same_cycle_no_swap", nf_cnt - nf0, 0);
    check("same_cycle_pending", frame_pending, 1);
    turn_tick = 1'b0;
    @(negedge clk);
    turn_tick = 1'b1;
    @(negedge clk);
    check("same_cycle_next_edge", bus.new_frame, 1);
    check("same_cycle_count", frame_count, 3);
    turn_tick = 1'b0;
    mem_check("same_cycle");
    @(negedge clk);

    // Garbage in IDLE, reset at word 1000, then a clean frame.
    s0 = strobe_cnt;
    for (int i = 0; i < 5; i++) send(DW'(128'hBAD0 + i), 1'b0);
    @(negedge clk);
    check("garbage_writes", strobe_cnt - s0, 0);
    fill_frame();
    for (int k = 0; k < 1000; k++) send(frm[k], k == 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    nf0 = nf_cnt;
    @(negedge clk);
    repeat (3) begin
      turn_tick = 1'b1; repeat (3) @(negedge clk);
      turn_tick = 1'b0; repeat (3) @(negedge clk);
    end
    check("midrst_ticks_no_swap", nf_cnt - nf0, 0);
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) send(frm[1000 + i], 1'b0);
    @(negedge clk);
    check("midrst_nosof_writes", strobe_cnt - s0, 0);
    fill_frame();
    for (int k = 0; k < FW; k++) send(frm[k], k == 0);
    mem_check("post_rst");
    turn_tick = 1'b1;
    @(negedge clk);
    check("post_rst_new_frame", bus.new_frame, 1);
    check("post_rst_count", frame_count, 1);
    turn_tick = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/frame_write_scheduler.md
# frame_write_scheduler

Sequences frame loading from the HPS stream into the back buffers of `NB_BANDS` `led_band_controller` instances, then issues a synchronized `new_frame` swap on the next rotation tick. Sits between the HPS data path and the band controllers' `w_addr_input`/`w_data`/`write`/`new_frame` ports. It guarantees that no band's back buffer is written between frame completion and the swap, and that all bands swap in the same cycle.

## Interface
Parameters:
- `NB_BANDS`, 2, number of led_band_controller instances fed
- `BIT_PER_COLOR`, 8, bits per color component
- `NB_LED_COLUMN`, 32, LEDs per band column
- `NB_ANGLES`, 128, angular positions per turn
- `W_DATA_WIDTH`, 128, write word width
- Derived: `HALF_WORDS = 3*BIT_PER_COLOR*NB_LED_COLUMN*NB_ANGLES/W_DATA_WIDTH` (768 at defaults); `ADDR_W = $clog2(HALF_WORDS)` (10); `BAND_W = max(1,$clog2(NB_BANDS))`

Ports:
- `clk` in 1, system clock
- `rst` in 1, synchronous active-high reset
- `in_valid` in 1, stream word valid
- `in_ready` out 1, stream word accepted when `in_valid && in_ready`
- `in_data` in `W_DATA_WIDTH`, stream word
- `in_sof` in 1, marks first word of a frame
- `turn_tick` in 1, rotation reference; multi-cycle level pulse, rising edge used
- `err_clr` in 1, clears `frame_error`
- `w_addr_input` out `ADDR_W`, shared write address to all bands
- `w_data` out `W_DATA_WIDTH`, shared write data
- `write` out `NB_BANDS`, one-hot write strobe, bit b targets band b
- `new_frame` out 1, one-cycle swap pulse to all bands
- `frame_pending` out 1, complete frame waiting for tick
- `frame_error` out 1, sticky: frame restarted or truncated
- `frame_count` out 16, number of swaps issued, wraps

## Operation
- States: IDLE, LOAD, WAIT_TICK.
- Word order: band-major; word k of frame goes to band `k / HALF_WORDS`, address `k % HALF_WORDS`. Counters: `addr` (ADDR_W) and `band` (BAND_W).
- IDLE: `in_ready`=1. A word without `in_sof` is accepted and discarded. A word with `in_sof` is written as band 0/addr 0, go LOAD with addr=1.
- LOAD: `in_ready`=1. Each accepted word is written to (band, addr); addr increments, wraps to 0 at `HALF_WORDS-1` and band increments. Accepting word `NB_BANDS*HALF_WORDS-1` goes to WAIT_TICK.
- LOAD with accepted `in_sof`: set `frame_error`, write that word as band 0/addr 0, addr=1, stay LOAD. The partial frame is never swapped.
- WAIT_TICK: `in_ready`=0, `frame_pending`=1. On the first `turn_tick` rising edge, pulse `new_frame`, increment `frame_count`, go IDLE.
- Tick edges in IDLE or LOAD are ignored (bands redisplay the previous frame).
- `frame_error` is set by restart only; cleared by `err_clr` or `rst`. Set takes priority over `err_clr` in the same cycle.

## Timing
- Reset values: `in_ready`=0 during the reset cycle, then 1 (IDLE); `write`=0, `w_addr_input`=0, `w_data`=0, `new_frame`=0, `frame_pending`=0, `frame_error`=0, `frame_count`=0. The tick edge-detect register resets to the current `turn_tick` value, so a tick held high through reset produces no edge.
- `write`, `w_addr_input` and `w_data` are registered: the strobe asserts exactly one cycle after the handshake, with address and data valid in that same cycle. Back-to-back handshakes produce back-to-back strobes.
- `in_ready` is a function of the registered state only. It drops in the cycle after the last word's handshake.
- Edge detect: `tick_edge = turn_tick & ~tick_d`, registered. `new_frame` asserts the cycle after the edge is seen in WAIT_TICK. `frame_pending` deasserts in the same cycle `new_frame` asserts.
- Simultaneous events: an edge in the same cycle as the last-word handshake is ignored; the block waits for the next edge. The last write strobe always precedes `new_frame` by at least one cycle.
- The earliest new stream word is accepted in the cycle after `new_frame`.
- A `rst` in the middle of a frame abandons it: no swap, counters return to 0, the next frame must start with `in_sof`.

## Test plan
- Nominal load (`NB_BANDS`=2): stream 1536 random words with `in_sof` on word 0, `in_valid` held high, then raise `turn_tick`. Required: band 0 memory words 0..767 equal stream words 0..767; band 1 memory equals words 768..1535; exactly 1536 single-bit strobes; `new_frame` one cycle, one cycle after the edge; `frame_count`=1.
- Backpressure and tick hold: after the frame completes, hold `in_valid`=1 and keep `turn_tick` high. Required: `in_ready`=0 until the swap; no `write`; exactly one `new_frame`, with no repeat while `turn_tick` stays high.
- Restart: send `in_sof` at word 300, then a full 1536-word frame. Required: `frame_error`=1; the restart word is written to band 0/addr 0; the swap occurs only after the second frame completes; `err_clr` returns `frame_error` to 0.
- Same-cycle tick: the `turn_tick` rising edge coincides with the last-word handshake. Required: no `new_frame` on that edge; `new_frame` on the next edge.
- IDLE garbage and reset mid-frame: send 5 words without `in_sof`, which must produce no `write`. Assert `rst` at word 1000. Required: all outputs at reset values; ticks cause no `new_frame` until a new complete frame has been loaded.
- Ticks during LOAD: three `turn_tick` edges during loading. Required: `new_frame`=0 throughout and `frame_count` unchanged.
